// File: rtl/pow_n_multi_cycle_hs.sv
// pow_n_multi_cycle_hs: n**e with a runtime exponent, one multiply per enabled cycle, ready/valid input
// Define POW_OVERFLOW_DETECT_EN to flag results truncated to W bits on res_ovf.
module pow_n_multi_cycle_hs #(
  parameter int W     = 8,
  parameter int EXP_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             arg_vld,
  output logic             arg_rdy,
  input  logic [W-1:0]     n,
  input  logic [EXP_W-1:0] e,
  output logic             res_vld,
  output logic [W-1:0]     res,
  output logic             res_ovf
);
  typedef enum logic {IDLE, CALC} state_t;
  state_t           state;
  logic [W-1:0]     n_q, acc;
  logic [EXP_W-1:0] cnt;
`ifdef POW_OVERFLOW_DETECT_EN
  logic [2*W-1:0] prod;
  logic           flag;
  assign prod = {{W{1'b0}}, acc} * {{W{1'b0}}, n_q};
  // Sticky per-operation truncation flag, published alongside res
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      flag    <= 1'b0;
      res_ovf <= 1'b0;
    end else if (clk_en) begin
      if (state == IDLE && arg_vld) flag <= 1'b0;
      else if (state == CALC && cnt != '0) flag <= flag | (|prod[2*W-1:W]);
      else if (state == CALC) res_ovf <= flag;
    end
`else
  logic [W-1:0] prod;
  assign prod    = acc * n_q;
  assign res_ovf = 1'b0;
`endif
  assign arg_rdy = state == IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      n_q     <= '0;
      cnt     <= '0;
      acc     <= '0;
      res     <= '0;
      res_vld <= 1'b0;
    end else if (clk_en) begin
      res_vld <= 1'b0;
      if (state == IDLE) begin
        if (arg_vld) begin
          n_q   <= n;
          cnt   <= e;
          acc   <= W'(1);
          state <= CALC;
        end
      end else if (cnt != '0) begin
        acc <= prod[W-1:0];
        cnt <= cnt - 1'b1;
      end else begin
        res     <= acc;
        res_vld <= 1'b1;
        state   <= IDLE;
      end
    end
endmodule

// File: tb/tb_pow_n_multi_cycle_hs.sv
// tb_pow_n_multi_cycle_hs: directed self-checking bench for pow_n_multi_cycle_hs
module tb_pow_n_multi_cycle_hs;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_en = 1'b1;
  logic       arg_vld = 1'b0;
  logic       arg_rdy;
  logic [7:0] n = '0;
  logic [2:0] e = '0;
  logic       res_vld;
  logic [7:0] res;
  logic       res_ovf;
  int         asserts = 0;
  int         failures = 0;
`ifdef POW_OVERFLOW_DETECT_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  pow_n_multi_cycle_hs #(.W(8), .EXP_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .arg_vld(arg_vld), .arg_rdy(arg_rdy),
    .n(n), .e(e), .res_vld(res_vld), .res(res), .res_ovf(res_ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_op(input logic [7:0] nv, input logic [2:0] ev, output int lat);
    arg_vld = 1'b1;
    n = nv;
    e = ev;
    step();
    arg_vld = 1'b0;
    n = 'x;
    e = 'x;
    lat = 0;
    while (!res_vld && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    asserts++;
    if (arg_rdy !== 1'b1 || res_vld !== 1'b0 || res !== 8'd0 || res_ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset: rdy=%b vld=%b res=%0d ovf=%b, want 1 0 0 0", arg_rdy, res_vld, res, res_ovf);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int lat;
    run_op(8'd3, 3'd5, lat);
    asserts++;
    if (lat !== 6 || res !== 8'd243 || res_ovf !== 1'b0 || arg_rdy !== 1'b1) begin
      failures++;
      $display("FAIL pow3_5: lat=%0d res=%0d ovf=%b rdy=%b, want 6 243 0 1", lat, res, res_ovf, arg_rdy);
    end
    step();
    asserts++;
    if (res_vld !== 1'b0 || res !== 8'd243) begin
      failures++;
      $display("FAIL pulse: vld=%b res=%0d, want 0 243", res_vld, res);
    end
  endtask

  task automatic test_edges();
    int lat;
    logic [7:0] nv [5] = '{8'd9, 8'd0, 8'd0, 8'd1, 8'd1};
    logic [2:0] ev [5] = '{3'd0, 3'd4, 3'd0, 3'd7, 3'd0};
    logic [7:0] rv [5] = '{8'd1, 8'd0, 8'd1, 8'd1, 8'd1};
    for (int i = 0; i < 5; i++) begin
      run_op(nv[i], ev[i], lat);
      asserts++;
      if (lat !== int'(ev[i]) + 1 || res !== rv[i] || res_ovf !== 1'b0) begin
        failures++;
        $display("FAIL edge%0d n=%0d e=%0d: lat=%0d res=%0d ovf=%b, want %0d %0d 0",
                 i, nv[i], ev[i], lat, res, res_ovf, ev[i] + 1, rv[i]);
      end
    end
  endtask

  task automatic test_trunc();
    int lat;
    run_op(8'd3, 3'd6, lat);
    asserts++;
    if (lat !== 7 || res !== 8'd217 || res_ovf !== OVF_EXP) begin
      failures++;
      $display("FAIL trunc3_6: lat=%0d res=%0d ovf=%b, want 7 217 %b", lat, res, res_ovf, OVF_EXP);
    end
    run_op(8'd2, 3'd7, lat);
    asserts++;
    if (lat !== 8 || res !== 8'd128 || res_ovf !== 1'b0) begin
      failures++;
      $display("FAIL pow2_7: lat=%0d res=%0d ovf=%b, want 8 128 0", lat, res, res_ovf);
    end
  endtask

  task automatic test_clk_en();
    int en_edges = 0;
    int guard = 0;
    arg_vld = 1'b1;
    n = 8'd2;
    e = 3'd7;
    step();
    arg_vld = 1'b0;
    n = 'x;
    e = 'x;
    while (!res_vld && guard < 60) begin
      clk_en = guard[0];
      step();
      if (clk_en) en_edges++;
      guard++;
    end
    asserts++;
    if (en_edges !== 8 || res !== 8'd128) begin
      failures++;
      $display("FAIL clk_en_lat: edges=%0d res=%0d, want 8 128", en_edges, res);
    end
    clk_en = 1'b0;
    arg_vld = 1'bx;
    repeat (3) step();
    asserts++;
    if (res_vld !== 1'b1 || res !== 8'd128 || arg_rdy !== 1'b1) begin
      failures++;
      $display("FAIL clk_en_hold: vld=%b res=%0d rdy=%b, want 1 128 1", res_vld, res, arg_rdy);
    end
    arg_vld = 1'b0;
    clk_en = 1'b1;
    step();
    asserts++;
    if (res_vld !== 1'b0 || arg_rdy !== 1'b1) begin
      failures++;
      $display("FAIL clk_en_clear: vld=%b rdy=%b, want 0 1", res_vld, arg_rdy);
    end
  endtask

  task automatic test_back_to_back();
    int lat = 0;
    arg_vld = 1'b1;
    n = 8'd5;
    e = 3'd3;
    step();
    n = 8'd7;
    e = 3'd2;
    asserts++;
    if (arg_rdy !== 1'b0) begin
      failures++;
      $display("FAIL busy_rdy: rdy=%b, want 0", arg_rdy);
    end
    while (!res_vld && lat < 40) begin
      step();
      lat++;
    end
    asserts++;
    if (lat !== 4 || res !== 8'd125 || arg_rdy !== 1'b1) begin
      failures++;
      $display("FAIL pow5_3: lat=%0d res=%0d rdy=%b, want 4 125 1", lat, res, arg_rdy);
    end
    step();
    arg_vld = 1'b0;
    asserts++;
    if (arg_rdy !== 1'b0 || res_vld !== 1'b0) begin
      failures++;
      $display("FAIL second_accept: rdy=%b vld=%b, want 0 0", arg_rdy, res_vld);
    end
    lat = 0;
    while (!res_vld && lat < 40) begin
      step();
      lat++;
    end
    asserts++;
    if (lat !== 3 || res !== 8'd49) begin
      failures++;
      $display("FAIL pow7_2: lat=%0d res=%0d, want 3 49", lat, res);
    end
  endtask

  task automatic test_abort();
    int lat;
    int pulses = 0;
    arg_vld = 1'b1;
    n = 8'd3;
    e = 3'd7;
    step();
    arg_vld = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    asserts++;
    if (arg_rdy !== 1'b1 || res !== 8'd0) begin
      failures++;
      $display("FAIL async_rst: rdy=%b res=%0d, want 1 0", arg_rdy, res);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (res_vld) pulses++;
    end
    asserts++;
    if (pulses !== 0 || arg_rdy !== 1'b1 || res !== 8'd0) begin
      failures++;
      $display("FAIL abort: pulses=%0d rdy=%b res=%0d, want 0 1 0", pulses, arg_rdy, res);
    end
    run_op(8'd2, 3'd4, lat);
    asserts++;
    if (lat !== 5 || res !== 8'd16) begin
      failures++;
      $display("FAIL after_abort: lat=%0d res=%0d, want 5 16", lat, res);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_trunc();
    test_clk_en();
    test_back_to_back();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end
endmodule
